// File: rtl/j1b_io_fifo.sv
// Multi-channel byte I/O bridge between the J1 io_rd/io_wr bus and byte-serial devices.
// Each channel has a TX FIFO (CPU->device), an RX FIFO (device->CPU) and data/status registers.
module j1b_io_fifo #(
    parameter int unsigned NCHAN       = 2,
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter logic [15:0] DATA_BASE   = 16'h1000,
    parameter logic [15:0] STAT_BASE   = 16'h2000,
    parameter logic [15:0] CHAN_STRIDE = 16'h0010
) (
    input  logic                 clk,
    input  logic                 resetq,
    input  logic                 io_rd,
    input  logic                 io_wr,
    input  logic [15:0]          mem_addr,
    input  logic [31:0]          dout,
    output logic [31:0]          io_din,
    output logic [8*NCHAN-1:0]   tx_data,
    output logic [NCHAN-1:0]     tx_valid,
    input  logic [NCHAN-1:0]     tx_ready,
    input  logic [8*NCHAN-1:0]   rx_data,
    input  logic [NCHAN-1:0]     rx_stb
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic              io_rd_q;
    logic              io_wr_q;
    logic [15:0]       io_addr_q;
    logic [31:0]       dout_q;
    logic [32*NCHAN-1:0] chan_rdata;

    // Same registered decode as the j1b top: address holds between accesses.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            io_rd_q   <= 1'b0;
            io_wr_q   <= 1'b0;
            io_addr_q <= 16'd0;
            dout_q    <= 32'd0;
        end else begin
            io_rd_q <= io_rd;
            io_wr_q <= io_wr;
            dout_q  <= dout;
            if (io_rd | io_wr) begin
                io_addr_q <= mem_addr;
            end
        end
    end

    logic unused_dout;
    assign unused_dout = ^dout_q[31:8];

    for (genvar n = 0; n < NCHAN; n++) begin : g_chan
        localparam logic [15:0] DATA_ADDR = DATA_BASE + 16'(n) * CHAN_STRIDE;
        localparam logic [15:0] STAT_ADDR = STAT_BASE + 16'(n) * CHAN_STRIDE;

        logic [7:0]    tx_mem [DEPTH];
        logic [7:0]    rx_mem [DEPTH];
        logic [PW-1:0] tx_rd_q, tx_wr_q, rx_rd_q, rx_wr_q;
        logic [CW-1:0] tx_cnt_q, rx_cnt_q;
        logic          tx_ovr_q, rx_ovf_q;

        logic data_hit, stat_hit, cpu_wr, cpu_rd, stat_wr;
        logic tx_empty, tx_full, rx_empty, rx_full;
        logic tx_push, tx_pop, rx_push, rx_pop, tx_ovr_set, rx_ovf_set;
        logic [7:0]  rx_head;
        logic [7:0]  rx_occ;
        logic [31:0] rdata;

        always_comb begin
            data_hit   = (io_addr_q == DATA_ADDR);
            stat_hit   = (io_addr_q == STAT_ADDR);
            cpu_wr     = io_wr_q & data_hit;
            cpu_rd     = io_rd_q & data_hit;
            stat_wr    = io_wr_q & stat_hit;
            tx_empty   = (tx_cnt_q == '0);
            tx_full    = (tx_cnt_q == FULL_CNT);
            rx_empty   = (rx_cnt_q == '0);
            rx_full    = (rx_cnt_q == FULL_CNT);
            // A same-cycle pop frees the slot, so a full FIFO can still accept.
            tx_pop     = tx_ready[n] & ~tx_empty;
            tx_push    = cpu_wr & (~tx_full | tx_pop);
            tx_ovr_set = cpu_wr & tx_full & ~tx_pop;
            rx_pop     = cpu_rd & ~rx_empty;
            rx_push    = rx_stb[n] & (~rx_full | rx_pop);
            rx_ovf_set = rx_stb[n] & rx_full & ~rx_pop;
            rx_head    = rx_empty ? 8'd0 : rx_mem[rx_rd_q];
            rx_occ     = 8'(rx_cnt_q);
        end

        always_comb begin
            rdata = 32'd0;
            if (data_hit) begin
                rdata = {24'd0, rx_head};
            end else if (stat_hit) begin
                rdata = {16'd0, rx_occ, 3'd0, tx_empty, tx_ovr_q, rx_ovf_q, ~rx_empty, ~tx_full};
            end
        end

        always_ff @(posedge clk or negedge resetq) begin
            if (!resetq) begin
                tx_rd_q  <= '0;
                tx_wr_q  <= '0;
                tx_cnt_q <= '0;
                tx_ovr_q <= 1'b0;
                rx_rd_q  <= '0;
                rx_wr_q  <= '0;
                rx_cnt_q <= '0;
                rx_ovf_q <= 1'b0;
            end else begin
                if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
                if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
                if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
                if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
                tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
                rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
                // W1C with set taking priority over a same-cycle clear.
                tx_ovr_q <= tx_ovr_set | (tx_ovr_q & ~(stat_wr & dout_q[3]));
                rx_ovf_q <= rx_ovf_set | (rx_ovf_q & ~(stat_wr & dout_q[2]));
            end
        end

        always_ff @(posedge clk) begin
            if (tx_push) tx_mem[tx_wr_q] <= dout_q[7:0];
            if (rx_push) rx_mem[rx_wr_q] <= rx_data[8*n +: 8];
        end

        assign tx_valid[n]           = ~tx_empty;
        assign tx_data[8*n +: 8]     = tx_empty ? 8'd0 : tx_mem[tx_rd_q];
        assign chan_rdata[32*n +: 32] = rdata;
    end

    // Addresses are disjoint, so at most one channel drives non-zero read data.
    always_comb begin
        io_din = 32'd0;
        for (int unsigned n = 0; n < NCHAN; n++) begin
            io_din = io_din | chan_rdata[32*n +: 32];
        end
    end

endmodule

// File: tb/tb_j1b_io_fifo.sv
// Bench for j1b_io_fifo: directed and random bus/device traffic checked against a
// queue-based channel model through read-data and TX-byte scoreboards.
module tb_j1b_io_fifo;
    localparam int NCHAN = 2;
    localparam int DEPTH = 16;
    localparam logic [15:0] DATA_BASE = 16'h1000;
    localparam logic [15:0] STAT_BASE = 16'h2000;
    localparam logic [15:0] STRIDE    = 16'h0010;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_t;

    logic               clk = 1'b0;
    logic               resetq = 1'b0;
    logic               io_rd = 1'b0;
    logic               io_wr = 1'b0;
    logic [15:0]        mem_addr = 16'd0;
    logic [31:0]        dout = 32'd0;
    logic [31:0]        io_din;
    logic [8*NCHAN-1:0] tx_data;
    logic [NCHAN-1:0]   tx_valid;
    logic [NCHAN-1:0]   tx_ready = '0;
    logic [8*NCHAN-1:0] rx_data = '0;
    logic [NCHAN-1:0]   rx_stb = '0;

    j1b_io_fifo #(
        .NCHAN(NCHAN), .DEPTH_LOG2(4), .DATA_BASE(DATA_BASE), .STAT_BASE(STAT_BASE),
        .CHAN_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .mem_addr(mem_addr),
        .dout(dout), .io_din(io_din), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_stb(rx_stb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: per-channel queues and counters, updated once per clock edge.
    logic [7:0]  rx_q [NCHAN][$];
    logic [7:0]  tx_sb [NCHAN][$];
    int          tx_cnt [NCHAN];
    bit          rx_ovf [NCHAN];
    bit          tx_ovr [NCHAN];
    logic [31:0] exp_q [$];
    bus_t               p1_bus, p2_bus;
    logic [NCHAN-1:0]   p1_stb, p1_rdy;
    logic [8*NCHAN-1:0] p1_rxd;
    logic [NCHAN-1:0]   g_rdy = '0;

    function automatic logic [31:0] model_read(logic [15:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int n = 0; n < NCHAN; n++) begin
            if (a == DATA_BASE + 16'(n) * STRIDE && rx_q[n].size() > 0) v = {24'd0, rx_q[n][0]};
            if (a == STAT_BASE + 16'(n) * STRIDE) begin
                v[0]    = tx_cnt[n] < DEPTH;
                v[1]    = rx_q[n].size() != 0;
                v[2]    = rx_ovf[n];
                v[3]    = tx_ovr[n];
                v[4]    = tx_cnt[n] == 0;
                v[15:8] = 8'(rx_q[n].size());
            end
        end
        return v;
    endfunction

    task automatic model_edge();
        for (int n = 0; n < NCHAN; n++) begin
            bit rd_hit, wr_hit, st_wr, ovf_set, ovr_set;
            rd_hit  = p2_bus.rd && p2_bus.addr == DATA_BASE + 16'(n) * STRIDE;
            wr_hit  = p2_bus.wr && p2_bus.addr == DATA_BASE + 16'(n) * STRIDE;
            st_wr   = p2_bus.wr && p2_bus.addr == STAT_BASE + 16'(n) * STRIDE;
            ovf_set = 1'b0;
            ovr_set = 1'b0;
            if (rd_hit && rx_q[n].size() > 0) void'(rx_q[n].pop_front());
            if (p1_stb[n]) begin
                if (rx_q[n].size() < DEPTH) rx_q[n].push_back(p1_rxd[8*n +: 8]);
                else ovf_set = 1'b1;
            end
            if (p1_rdy[n] && tx_cnt[n] > 0) tx_cnt[n]--;
            if (wr_hit) begin
                if (tx_cnt[n] < DEPTH) begin
                    tx_cnt[n]++;
                    tx_sb[n].push_back(p2_bus.data[7:0]);
                end else begin
                    ovr_set = 1'b1;
                end
            end
            rx_ovf[n] = ovf_set || (rx_ovf[n] && !(st_wr && p2_bus.data[2]));
            tx_ovr[n] = ovr_set || (tx_ovr[n] && !(st_wr && p2_bus.data[3]));
        end
    endtask

    task automatic step(input bus_t b, input logic [NCHAN-1:0] stb,
                        input logic [8*NCHAN-1:0] rxd, input logic [NCHAN-1:0] rdy);
        @(posedge clk);
        model_edge();
        if (p1_bus.rd) exp_q.push_back(model_read(p1_bus.addr));
        p2_bus = p1_bus;
        p1_bus = b;
        p1_stb = stb;
        p1_rxd = rxd;
        p1_rdy = rdy;
        #1;
        io_rd = b.rd; io_wr = b.wr; mem_addr = b.addr; dout = b.data;
        rx_stb = stb; rx_data = rxd; tx_ready = rdy;
    endtask

    function automatic bus_t mk(logic r, logic w, logic [15:0] a, logic [31:0] d);
        bus_t b;
        b.rd = r; b.wr = w; b.addr = a; b.data = d;
        return b;
    endfunction

    task automatic idle(int k);
        repeat (k) step(mk(1'b0, 1'b0, 16'd0, 32'd0), '0, '0, g_rdy);
    endtask

    task automatic rd(logic [15:0] a);
        step(mk(1'b1, 1'b0, a, 32'd0), '0, '0, g_rdy);
    endtask

    task automatic wr(logic [15:0] a, logic [31:0] d);
        step(mk(1'b0, 1'b1, a, d), '0, '0, g_rdy);
    endtask

    task automatic strobe(int ch, logic [7:0] d, input bus_t b);
        logic [NCHAN-1:0]   s;
        logic [8*NCHAN-1:0] x;
        s = '0; x = '0;
        s[ch] = 1'b1;
        x[8*ch +: 8] = d;
        step(b, s, x, g_rdy);
    endtask

    // Read a register and compare the returned word with a literal as well.
    task automatic rd_expect(string name, logic [15:0] a, logic [31:0] v);
        rd(a);
        idle(1);
        check(name, io_din, v);
    endtask

    task automatic do_reset(int cycles);
        @(posedge clk);
        #1;
        resetq = 1'b0;
        io_rd = 1'b0; io_wr = 1'b0; mem_addr = 16'd0; dout = 32'd0;
        rx_stb = '0; tx_ready = '0; rx_data = '0;
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_io_din", io_din, 32'd0);
        for (int n = 0; n < NCHAN; n++) begin
            rx_q[n].delete();
            tx_sb[n].delete();
            tx_cnt[n] = 0;
            rx_ovf[n] = 1'b0;
            tx_ovr[n] = 1'b0;
        end
        exp_q.delete();
        p1_bus = '0; p2_bus = '0; p1_stb = '0; p1_rdy = '0; p1_rxd = '0;
        repeat (cycles) @(posedge clk);
        #1 resetq = 1'b1;
    endtask

    // Monitor: read data the cycle after io_rd, TX bytes whenever the device takes one.
    logic rd_d;
    always @(posedge clk or negedge resetq) begin
        if (!resetq) rd_d <= 1'b0;
        else         rd_d <= io_rd;
    end

    always @(negedge clk) begin
        if (resetq) begin
            if (rd_d) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL io_din: got %h with no expected read pending", io_din);
                end else begin
                    check("io_din", io_din, exp_q.pop_front());
                end
            end
            for (int n = 0; n < NCHAN; n++) begin
                if (tx_valid[n] && tx_ready[n]) begin
                    if (tx_sb[n].size() == 0) begin
                        checks++; failures++;
                        $display("FAIL tx_byte ch%0d: got %h expected no byte", n, tx_data[8*n +: 8]);
                    end else begin
                        check($sformatf("tx_byte ch%0d", n), 32'(tx_data[8*n +: 8]),
                              32'(tx_sb[n].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bus_t b;
        int   rx_pct, rdy_pct, r;
        logic [15:0] a;
        logic [NCHAN-1:0]   s, y;
        logic [8*NCHAN-1:0] x;

        do_reset(3);
        rd_expect("rst_stat0", STAT_BASE, 32'h0011);
        rd_expect("rst_stat1", STAT_BASE + STRIDE, 32'h0011);

        // TX path: latency, overrun on the 17th byte, W1C clear, drain.
        g_rdy = '0;
        wr(DATA_BASE, 32'h41);
        idle(1);
        check("tx_lat_1cyc", 32'(tx_valid[0]), 32'd0);
        idle(1);
        check("tx_lat_2cyc", 32'(tx_valid[0]), 32'd1);
        check("tx_head", 32'(tx_data[7:0]), 32'h41);
        for (int i = 0; i < 16; i++) wr(DATA_BASE, 32'h50 + i);
        idle(2);
        rd_expect("tx_ovr_stat", STAT_BASE, 32'h0008);
        wr(STAT_BASE, 32'h8);
        idle(1);
        rd_expect("tx_ovr_clr", STAT_BASE, 32'h0000);
        rd_expect("iso_ch1", STAT_BASE + STRIDE, 32'h0011);
        g_rdy = 2'b01;
        idle(20);
        check("tx_drained", 32'(tx_valid), 32'd0);
        g_rdy = '0;

        // RX path on channel 1, including an empty read.
        for (int i = 0; i < 3; i++) strobe(1, 8'h10 + 8'(i), mk(1'b0, 1'b0, 16'd0, 32'd0));
        idle(1);
        rd_expect("rx_occ3", STAT_BASE + STRIDE, 32'h0313);
        for (int i = 0; i < 4; i++) begin
            rd(DATA_BASE + STRIDE);
            idle(1);
        end
        rd_expect("rx_empty_after", STAT_BASE + STRIDE, 32'h0011);

        // RX overflow on channel 0, then push alongside a pop while full.
        for (int i = 0; i < 17; i++) strobe(0, 8'(8'h80 + i), mk(1'b0, 1'b0, 16'd0, 32'd0));
        idle(1);
        rd_expect("rx_ovf_stat", STAT_BASE, 32'h1017);
        rd(DATA_BASE);
        strobe(0, 8'hAA, mk(1'b0, 1'b0, 16'd0, 32'd0));
        idle(1);
        rd_expect("rx_full_pop_push", STAT_BASE, 32'h1017);
        wr(STAT_BASE, 32'h4);
        idle(1);
        rd_expect("rx_ovf_clr", STAT_BASE, 32'h1013);
        rd_expect("bad_addr", DATA_BASE + 16'(NCHAN) * STRIDE, 32'd0);
        rd_expect("bad_stat", STAT_BASE + 16'(NCHAN) * STRIDE, 32'd0);
        for (int i = 0; i < 17; i++) begin
            rd(DATA_BASE);
            idle(1);
        end

        // Pointer wrap: 40 push/pop pairs on channel 1.
        for (int i = 0; i < 40; i++) strobe(1, 8'(i * 7 + 3), mk(1'b1, 1'b0, DATA_BASE + STRIDE, 0));
        idle(2);

        // Random traffic with varying device rates and a reset in the middle.
        for (int blk = 0; blk < 6; blk++) begin
            rx_pct  = $urandom_range(5, 40);
            rdy_pct = $urandom_range(0, 70);
            if (blk == 3) begin
                do_reset(2);
                rd_expect("mid_rst_stat0", STAT_BASE, 32'h0011);
                rd_expect("mid_rst_stat1", STAT_BASE + STRIDE, 32'h0011);
            end
            for (int c = 0; c < 400; c++) begin
                case ($urandom_range(0, 5))
                    0: a = DATA_BASE;
                    1: a = DATA_BASE + STRIDE;
                    2: a = STAT_BASE;
                    3: a = STAT_BASE + STRIDE;
                    4: a = DATA_BASE + 16'(NCHAN) * STRIDE;
                    default: a = 16'($urandom);
                endcase
                r = $urandom_range(0, 99);
                b = mk(r < 30, r >= 30 && r < 55, a, $urandom);
                s = '0; y = '0;
                x = 16'($urandom);
                for (int n = 0; n < NCHAN; n++) begin
                    s[n] = $urandom_range(0, 99) < rx_pct;
                    y[n] = $urandom_range(0, 99) < rdy_pct;
                end
                step(b, s, x, y);
            end
        end

        g_rdy = '1;
        idle(40);
        rd(STAT_BASE);
        rd(STAT_BASE + STRIDE);
        idle(3);
        check("sb_reads_left", 32'(exp_q.size()), 32'd0);
        check("sb_tx0_left", 32'(tx_sb[0].size()), 32'd0);
        check("sb_tx1_left", 32'(tx_sb[1].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
